pin_shutdown_ctrl: RTL and testbench
====================================

// Module: pin_shutdown_ctrl
//
// PURPOSE
// Safety sequencer that drives pin_shutdown into the output pin configuration block.
// Holds outputs in shutdown until software arms it over the Wishbone register bus.
// Trips and latches shutdown on a filtered external fault, a watchdog expiry or a
// software request. Sits beside the pin config block on the same Wishbone slave decode.
//
// PARAMETERS
// WDT_BITS    16  width of watchdog timeout register and down-counter
// FILT_BITS    8  width of fault filter length register and counter
//
// PORTS
// clk           in   1   system clock
// rst_n         in   1   asynchronous active-low reset
// fault_in      in   1   external fault, asynchronous to clk, active-high
// pin_shutdown  out  1   1 = force outputs to shutdown; to pin config block
// irq           out  1   trip interrupt, level, registered
// wb_stb_i      in   1   Wishbone strobe
// wb_cyc_i      in   1   Wishbone cycle
// wb_we_i       in   1   Wishbone write enable
// wb_adr_i      in   4   register index
// wb_dat_i      in   32  write data
// wb_dat_o      out  32  read data, combinational from addressed register
// wb_ack_o      out  1   tied 1 (zero-wait-state slave)
//
// BEHAVIOUR
// - Reset is asynchronous and active-low; one clock (clk). On reset: state=DISARMED,
//   pin_shutdown=1, irq=0, cause=0, wdt_timeout=0, wdt_cnt=0, filt_len=0,
//   filter counter=0, sync flops=0.
// - A write is accepted when wb_cyc_i & wb_stb_i & wb_we_i. Reads have no side effects.
// - Register map (wb_adr_i):
//   - 0 CTRL (W): bit0 ARM, bit1 CLEAR, bit2 SWSHUT.
//     Read: {29'0, state==TRIPPED, state==ARMED, filtered_fault}.
//   - 1 WDT_TIMEOUT (R/W): [WDT_BITS-1:0]. 0 disables the watchdog.
//   - 2 WDT_FEED (W): any write reloads wdt_cnt<=wdt_timeout. Reads 0.
//   - 3 STATUS (R): {29'0, cause[2:0]}. cause[0]=fault, [1]=wdt, [2]=sw.
//   - 4 FILT_LEN (R/W): [FILT_BITS-1:0].
//   - Other addresses: read 0, writes ignored.
// - Fault filter: fault_in passes a 2-FF synchronizer. The counter increments (saturating)
//   while the synced value is 1 and clears to 0 when it is 0. filtered_fault =
//   synced & (cnt >= filt_len). filt_len=0 gives 2-cycle latency from fault_in.
// - FSM states: DISARMED, ARMED, TRIPPED. pin_shutdown = (state != ARMED), decoded from
//   the state flop, so it changes the cycle after the causing edge.
//   - DISARMED->ARMED: CTRL write with ARM=1, cause==0 and filtered_fault==0.
//     Same edge loads wdt_cnt<=wdt_timeout. If any condition fails, stay DISARMED.
//   - ARMED->DISARMED: CTRL write with ARM=0 and SWSHUT=0.
//   - ARMED->TRIPPED when any of these hold; every true cause bit is set the same edge,
//     and irq<=1:
//     - filtered_fault;
//     - wdt_timeout!=0 and wdt_cnt==1 and the cycle is not a feed;
//     - CTRL write with SWSHUT=1.
//   - TRIPPED->DISARMED: CTRL write with CLEAR=1. Clears cause and irq. ARM in the same
//     write is ignored; a separate write is required to arm.
//   - SWSHUT or fault while DISARMED: no state change, no cause bit set.
// - Watchdog: decrements by 1 each cycle in ARMED while the timeout is nonzero.
//   A feed on the expiry cycle wins, so no trip occurs. A WDT_TIMEOUT write takes effect
//   at the next feed or arm. The counter is frozen outside ARMED.
// - A mid-operation reset returns immediately to shutdown, with all latched causes lost.
//
// CONFIGURATION
// - KSTEP_SHUTDOWN_WDT_EN defined: watchdog logic, WDT_TIMEOUT and WDT_FEED present as
//   above.
// - Undefined: no watchdog counter; addresses 1 and 2 read 0 and writes are ignored;
//   cause[1] is constant 0. All other behaviour is identical.
//
// TESTING
// - After reset: pin_shutdown=1, STATUS=0. Write CTRL=1 -> pin_shutdown=0 the next cycle,
//   CTRL reads 0x2.
// - Armed, filt_len=3, fault_in high for 3 cycles then low -> no trip.
//   Fault_in high for 6 cycles -> TRIPPED, STATUS=0x1, irq=1.
// - WDT_TIMEOUT=10, arm, no feeds -> trip on the 10th armed cycle, STATUS=0x2.
//   Repeat, feeding every 8 cycles for 100 cycles -> stays ARMED.
// - Tripped: write CTRL=0x3 -> DISARMED, STATUS=0, irq=0, pin_shutdown stays 1.
//   Next write CTRL=1 -> ARMED.
// - Same cycle: filtered fault plus SWSHUT write -> STATUS=0x5.
//   Arm attempt while fault held -> remains DISARMED.
// - Assert rst_n low mid-ARMED, asynchronously between edges -> pin_shutdown=1 at once,
//   all registers at reset values.

Source files
------------

// File: rtl/pin_shutdown_ctrl_if.sv
// Wishbone register-bus bundle for pin_shutdown_ctrl: zero-wait-state slave,
// single-cycle transfers.
interface pin_shutdown_ctrl_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  // A transfer completes on every clock edge where wb_cyc_i & wb_stb_i are high;
  // wb_ack_o is tied high, so the slave never stalls and read data is combinational.
  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/pin_shutdown_ctrl.sv
// Safety sequencer driving pin_shutdown: arm/trip/clear FSM with fault filter.
// Watchdog present only when KSTEP_SHUTDOWN_WDT_EN is defined.
module pin_shutdown_ctrl #(
    parameter int WDT_BITS  = 16,
    parameter int FILT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fault_in,
    output logic                    pin_shutdown,
    output logic                    irq,
    output logic [1:0]              state_dbg,
    pin_shutdown_ctrl_if.slave      wb
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        TRIPPED  = 2'd2
    } state_t;

    state_t                 state;
    logic [2:0]             cause;
    logic                   sync1, sync2;
    logic [FILT_BITS-1:0]   filt_cnt;
    logic [FILT_BITS-1:0]   filt_len;
    logic                   filtered_fault;
    logic                   wr_en, ctrl_wr, filt_wr;
    logic                   arm_ok, sw_req, wdt_trip;
    logic                   unused_dat;

    assign wr_en   = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i;
    assign ctrl_wr = wr_en && (wb.wb_adr_i == 4'd0);
    assign filt_wr = wr_en && (wb.wb_adr_i == 4'd4);
    assign unused_dat = ^wb.wb_dat_i;

    // fault_in is asynchronous: two flops before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            filt_cnt <= '0;
            filt_len <= '0;
        end else begin
            sync1 <= fault_in;
            sync2 <= sync1;
            if (!sync2)
                filt_cnt <= '0;
            else if (filt_cnt != '1)
                filt_cnt <= filt_cnt + FILT_BITS'(1);
            if (filt_wr)
                filt_len <= wb.wb_dat_i[FILT_BITS-1:0];
        end
    end

    assign filtered_fault = sync2 && (filt_cnt >= filt_len);
    assign arm_ok = ctrl_wr && wb.wb_dat_i[0] && (cause == 3'd0) && !filtered_fault;
    assign sw_req = ctrl_wr && wb.wb_dat_i[2];

`ifdef KSTEP_SHUTDOWN_WDT_EN
    logic [WDT_BITS-1:0] wdt_timeout;
    logic [WDT_BITS-1:0] wdt_cnt;
    logic                feed_wr;

    assign feed_wr  = wr_en && (wb.wb_adr_i == 4'd2);
    // A feed on the expiry cycle reloads the counter instead of tripping.
    assign wdt_trip = (wdt_timeout != '0) && (wdt_cnt == WDT_BITS'(1)) && !feed_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_timeout <= '0;
            wdt_cnt     <= '0;
        end else begin
            if (wr_en && (wb.wb_adr_i == 4'd1))
                wdt_timeout <= wb.wb_dat_i[WDT_BITS-1:0];
            if (feed_wr || (state == DISARMED && arm_ok))
                wdt_cnt <= wdt_timeout;
            else if (state == ARMED && wdt_timeout != '0 && wdt_cnt != '0)
                wdt_cnt <= wdt_cnt - WDT_BITS'(1);
        end
    end
`else
    assign wdt_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DISARMED;
            cause <= 3'd0;
            irq   <= 1'b0;
        end else begin
            case (state)
                DISARMED: if (arm_ok) state <= ARMED;
                ARMED: begin
                    if (filtered_fault || wdt_trip || sw_req) begin
                        state <= TRIPPED;
                        irq   <= 1'b1;
                        cause <= {sw_req, wdt_trip, filtered_fault};
                    end else if (ctrl_wr && !wb.wb_dat_i[0] && !wb.wb_dat_i[2]) begin
                        state <= DISARMED;
                    end
                end
                TRIPPED: begin
                    // ARM in the clearing write is deliberately ignored.
                    if (ctrl_wr && wb.wb_dat_i[1]) begin
                        state <= DISARMED;
                        cause <= 3'd0;
                        irq   <= 1'b0;
                    end
                end
                default: state <= DISARMED;
            endcase
        end
    end

    assign pin_shutdown = (state != ARMED);
    assign state_dbg    = state;
    assign wb.wb_ack_o  = 1'b1;

    always_comb begin
        wb.wb_dat_o = 32'd0;
        case (wb.wb_adr_i)
            4'd0: wb.wb_dat_o = {29'd0, state == TRIPPED, state == ARMED, filtered_fault};
`ifdef KSTEP_SHUTDOWN_WDT_EN
            4'd1: wb.wb_dat_o = {{(32-WDT_BITS){1'b0}}, wdt_timeout};
`endif
            4'd3: wb.wb_dat_o = {29'd0, cause};
            4'd4: wb.wb_dat_o = {{(32-FILT_BITS){1'b0}}, filt_len};
            default: wb.wb_dat_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_pin_shutdown_ctrl.sv
// Directed bench for pin_shutdown_ctrl: arm, filter, trip causes, clear, watchdog, reset.
module tb_pin_shutdown_ctrl;
  logic       clk;
  logic       rst_n;
  logic       fault_in;
  logic       pin_shutdown;
  logic       irq;
  logic [1:0] state_dbg;
  logic [31:0] rdata;
  int tests;
  int fails;

  localparam logic [1:0] S_DISARMED = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_TRIPPED  = 2'd2;

  pin_shutdown_ctrl_if wb();

  pin_shutdown_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fault_in     (fault_in),
    .pin_shutdown (pin_shutdown),
    .irq          (irq),
    .state_dbg    (state_dbg),
    .wb           (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b1;
    wb.wb_adr_i = a;
    wb.wb_dat_i = d;
    @(posedge clk);
    #1;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_dat_i = $urandom_range(0, 32'hFFFF) << 8;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = a;
    #1;
    d = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    fault_in = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = 4'd0;
    wb.wb_dat_i = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    chk("rst_pin", pin_shutdown, 1);
    chk("rst_irq", irq, 0);
    chk("rst_state", state_dbg, S_DISARMED);
    chk("rst_ack", wb.wb_ack_o, 1);
    rd(4'd3, rdata); chk("rst_status", rdata, 0);
    rd(4'd0, rdata); chk("rst_ctrl", rdata, 0);

    // Arm
    wr(4'd0, 32'h1);
    chk("arm_pin", pin_shutdown, 0);
    rd(4'd0, rdata); chk("arm_ctrl", rdata, 32'h2);

    // Filter length 3: a 3-cycle pulse is rejected, a 6-cycle one trips
    wr(4'd4, 32'h3);
    rd(4'd4, rdata); chk("filt_len_rd", rdata, 3);
    fault_in = 1'b1;
    tick(3);
    fault_in = 1'b0;
    tick(6);
    chk("short_fault_state", state_dbg, S_ARMED);
    rd(4'd3, rdata); chk("short_fault_status", rdata, 0);
    fault_in = 1'b1;
    tick(5);
    chk("long_fault_pre", state_dbg, S_ARMED);
    tick(1);
    chk("long_fault_state", state_dbg, S_TRIPPED);
    chk("long_fault_pin", pin_shutdown, 1);
    chk("long_fault_irq", irq, 1);
    rd(4'd3, rdata); chk("long_fault_status", rdata, 32'h1);
    rd(4'd0, rdata); chk("long_fault_ctrl", rdata, 32'h5);
    fault_in = 1'b0;
    tick(4);

    // Clear with ARM set only disarms; a second write arms
    wr(4'd0, 32'h3);
    chk("clear_state", state_dbg, S_DISARMED);
    chk("clear_irq", irq, 0);
    chk("clear_pin", pin_shutdown, 1);
    rd(4'd3, rdata); chk("clear_status", rdata, 0);
    wr(4'd0, 32'h1);
    chk("rearm_state", state_dbg, S_ARMED);

    // Filtered fault and SWSHUT on the same edge
    wr(4'd4, 32'h0);
    fault_in = 1'b1;
    tick(2);
    rd(4'd0, rdata); chk("filt0_ctrl", rdata, 32'h3);
    wr(4'd0, 32'h4);
    chk("both_state", state_dbg, S_TRIPPED);
    rd(4'd3, rdata); chk("both_status", rdata, 32'h5);

    // Arm refused while the fault is held; SWSHUT while disarmed does nothing
    wr(4'd0, 32'h2);
    wr(4'd0, 32'h1);
    chk("arm_blocked_state", state_dbg, S_DISARMED);
    chk("arm_blocked_pin", pin_shutdown, 1);
    wr(4'd0, 32'h4);
    chk("sw_disarmed_state", state_dbg, S_DISARMED);
    rd(4'd3, rdata); chk("sw_disarmed_status", rdata, 0);
    fault_in = 1'b0;
    tick(4);

    // Plain disarm from ARMED, and an unmapped address
    wr(4'd0, 32'h1);
    wr(4'd0, 32'h0);
    chk("disarm_state", state_dbg, S_DISARMED);
    wr(4'd7, 32'hFFFF_FFFF);
    rd(4'd7, rdata); chk("unmapped_rd", rdata, 0);
    rd(4'd2, rdata); chk("feed_rd", rdata, 0);

`ifdef KSTEP_SHUTDOWN_WDT_EN
    wr(4'd1, 32'd10);
    rd(4'd1, rdata); chk("wdt_to_rd", rdata, 10);
    wr(4'd0, 32'h1);
    tick(9);
    chk("wdt_pre_expiry", state_dbg, S_ARMED);
    tick(1);
    chk("wdt_trip_state", state_dbg, S_TRIPPED);
    chk("wdt_trip_irq", irq, 1);
    rd(4'd3, rdata); chk("wdt_status", rdata, 32'h2);
    wr(4'd0, 32'h2);
    wr(4'd0, 32'h1);
    for (int i = 0; i < 13; i++) begin
      tick(7);
      wr(4'd2, 32'h0);
    end
    chk("wdt_fed_state", state_dbg, S_ARMED);
    tick(9);
    wr(4'd2, 32'h0);
    chk("wdt_feed_on_expiry", state_dbg, S_ARMED);
    rd(4'd3, rdata); chk("wdt_feed_status", rdata, 0);
    wr(4'd0, 32'h0);
`else
    wr(4'd1, 32'd10);
    rd(4'd1, rdata); chk("wdt_absent_rd", rdata, 0);
    wr(4'd0, 32'h1);
    tick(20);
    chk("wdt_absent_state", state_dbg, S_ARMED);
    wr(4'd0, 32'h0);
`endif

    // Asynchronous reset in the middle of ARMED
    wr(4'd4, 32'h5);
    wr(4'd0, 32'h1);
    chk("pre_reset_pin", pin_shutdown, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pin", pin_shutdown, 1);
    chk("async_rst_state", state_dbg, S_DISARMED);
    chk("async_rst_irq", irq, 0);
    rd(4'd4, rdata); chk("async_rst_filt", rdata, 0);
    rd(4'd3, rdata); chk("async_rst_status", rdata, 0);
    rd(4'd1, rdata); chk("async_rst_wdt", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_state", state_dbg, S_DISARMED);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
